buffer_stream_ctrl: RTL and testbench
=====================================

# buffer_stream_ctrl

Controller that owns the single address port of the `memory_buffer` byte RAM.
- Captures a fixed-length block of bytes from an upstream AXI-Stream source (ADC sample packer) into the RAM.
- Then drains the block as one AXI-Stream frame, with `tlast`, toward the UDP payload path.
- The RAM has one shared address and a combinational read, so the block alternates strictly between a fill phase and a drain phase.

## Interface
- `NUM_FRAMES`, 1024, depth of the attached `memory_buffer` in bytes.
- `ADDR_WIDTH`, `$clog2(NUM_FRAMES)`, RAM address width.
- `LEN`, `NUM_FRAMES`, bytes per captured/drained frame; legal range 1..`NUM_FRAMES`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  8  upstream byte.
- `s_axis_tvalid`  in  1  upstream byte valid.
- `s_axis_tready`  out  1  registered; high only in FILL.
- `m_axis_tdata`  out  8  registered output byte.
- `m_axis_tvalid`  out  1  registered output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  registered; marks byte `LEN-1` of the frame.
- `mem_we`  out  1  RAM write enable; combinational, equal to `s_axis_tvalid && s_axis_tready`.
- `mem_addr`  out  `ADDR_WIDTH`  RAM address.
- `mem_wdata`  out  8  RAM write data; equal to `s_axis_tdata`.
- `mem_rdata`  in  8  RAM combinational read data.
- `frame_count`  out  16  completed drained frames; wraps modulo 2^16.

## Operation
- States: FILL, DRAIN, FLUSH. Reset state is FILL.
- **Reset values:**
  - `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast` = 0.
  - `m_axis_tdata` = 0, `frame_count` = 0.
  - Write and read pointers = 0.
- **FILL**
  - `s_axis_tready`=1; `mem_addr`=`wr_ptr`.
  - Each input handshake writes one byte at `wr_ptr`, then `wr_ptr`+1.
  - A handshake at `wr_ptr`==`LEN-1` moves to DRAIN, clears `rd_ptr`, and deasserts `s_axis_tready` on the same edge.
- **DRAIN**
  - `mem_addr`=`rd_ptr`; `mem_we`=0.
  - The output register loads `mem_rdata` when it is empty or its beat is accepted this cycle (`!m_axis_tvalid || m_axis_tready`).
  - On each such load, `m_axis_tlast` is set iff `rd_ptr`==`LEN-1`, and `rd_ptr` increments.
  - Loading the byte at `rd_ptr`==`LEN-1` moves to FLUSH.
- **FLUSH**
  - `mem_addr`=0; no RAM access.
  - Waits for acceptance of the beat with `tlast`=1; on that handshake: `m_axis_tvalid`→0, `frame_count`+1, `wr_ptr`=0, `s_axis_tready`→1, state→FILL.
- **Output stability:** `m_axis_tdata`/`tlast` are held stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- **Input while not in FILL:** bytes are never dropped; upstream is stalled by `s_axis_tready`=0.
- **`LEN`=1:** FILL takes one byte; DRAIN loads it with `tlast`=1 and goes straight to FLUSH.
- **Reset mid-operation:** partial fill or drain is discarded; all outputs take reset values at the edge where `rst_n`=0 is sampled.

## Timing
- `s_axis_tready` rises on the first edge after `rst_n` is released, and on the edge that completes a frame drain.
- The first output byte has `m_axis_tvalid`=1 on the cycle after DRAIN is entered (one cycle after the last fill handshake edge).
- Throughput is one byte per cycle in both phases with continuous valid/ready.
- Minimum frame period is `2*LEN+1` cycles: `LEN` fill, then `LEN` drain beats with the first beat one cycle after the last fill edge.
- Pointers count 0..`LEN-1`. They never reach `NUM_FRAMES` and need no modulo wrap.

## Structure
- Shared package/header `memory_buffer_pkg`: state encoding localparams (FILL, DRAIN, FLUSH) and the `frame_count` width (16).
- One natural sub-module: `axis_byte_out_reg`. It holds the registered `tdata`/`tvalid`/`tlast` stage with load-when-empty-or-accepted logic.
- The FSM, pointers and counter stay in the top module.

## Test plan
- **Basic (`LEN`=4, continuous streams):** input 0x11, 0x22, 0x33, 0x44 with `m_axis_tready`=1 → output 0x11..0x44 on 4 consecutive cycles, `tlast` only on 0x44, `frame_count`=1, `s_axis_tready` high again the following cycle.
- **Backpressure:** `m_axis_tready` toggled 1,0,0,1,… during drain → no byte lost or duplicated; `tdata` held stable across stalled cycles; order 0x11..0x44 preserved.
- **Fill stall:** `s_axis_tvalid` gaps during FILL → `mem_we` pulses only on handshakes; addresses 0,1,2,3 are written in order; drain matches.
- **Upstream push during drain:** `s_axis_tvalid` held high through DRAIN/FLUSH → `s_axis_tready`=0 and `mem_we`=0 throughout; the next frame starts at address 0.
- **Reset mid-drain:** `rst_n`=0 for one cycle after 2 output beats → `m_axis_tvalid`=0, `frame_count`=0, state FILL. A fresh 4-byte frame then drains correctly.
- **Edge cases:** `LEN`=1 (single beat with `tlast`=1); `frame_count` wrap 0xFFFF→0x0000 after 65536 frames (preload via force) → correct wrap.

Source files
------------

// File: rtl/memory_buffer_pkg.sv
// rtl/memory_buffer_pkg.sv - shared state encoding and counter width for the buffer stream controller
package memory_buffer_pkg;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/axis_byte_out_reg.sv
// rtl/axis_byte_out_reg.sv - registered byte stream output stage, loads when empty or when its beat leaves
module axis_byte_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       can_load,
  output logic [7:0] tdata,
  output logic       tvalid,
  output logic       tlast,
  input  logic       tready
);

  assign can_load = !tvalid || tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata  <= 8'd0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load && can_load) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
    end else if (tvalid && tready) begin
      // tdata is kept; only the valid/last qualifiers drop once the beat is taken
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/buffer_stream_ctrl.sv
// rtl/buffer_stream_ctrl.sv - fills a byte RAM from an input stream, then drains it as one framed output stream
module buffer_stream_ctrl
  import memory_buffer_pkg::*;
#(
  parameter int NUM_FRAMES = 1024,
  parameter int ADDR_WIDTH = $clog2(NUM_FRAMES),
  parameter int LEN        = NUM_FRAMES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LEN - 1);

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic                   s_ready_q;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   out_can_load;
  logic                   out_load;
  logic                   out_accept;

  assign s_axis_tready = s_ready_q;
  assign mem_we        = s_axis_tvalid && s_ready_q;
  assign mem_wdata     = s_axis_tdata;
  assign frame_count   = frame_cnt;
  assign out_load      = (state == ST_DRAIN) && out_can_load;
  assign out_accept    = m_axis_tvalid && m_axis_tready;

  // The RAM has a single port, so the address follows whichever phase owns it.
  always_comb begin
    mem_addr = '0;
    case (state)
      ST_FILL:  mem_addr = wr_ptr;
      ST_DRAIN: mem_addr = rd_ptr;
      default:  mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_q <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          s_ready_q <= !(mem_we && wr_ptr == LAST_IDX);
          if (mem_we) begin
            if (wr_ptr == LAST_IDX) begin
              state  <= ST_DRAIN;
              rd_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_load) begin
            if (rd_ptr == LAST_IDX) begin
              state <= ST_FLUSH;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Only the tlast beat can be pending here; its acceptance closes the frame.
          if (out_accept) begin
            state     <= ST_FILL;
            wr_ptr    <= '0;
            s_ready_q <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_FILL;
          wr_ptr    <= '0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  axis_byte_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .load_data (mem_rdata),
    .load_last (rd_ptr == LAST_IDX),
    .can_load  (out_can_load),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .tlast     (m_axis_tlast),
    .tready    (m_axis_tready)
  );

endmodule

// File: tb/tb_buffer_stream_ctrl.sv
// tb/tb_buffer_stream_ctrl.sv - directed self-checking bench for buffer_stream_ctrl with LEN=4 and LEN=1 instances
module tb_buffer_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_s_tdata = 8'd0, a_m_tdata, a_mem_wdata, a_mem_rdata;
  logic        a_s_tvalid = 1'b0, a_s_tready, a_m_tvalid, a_m_tready = 1'b0, a_m_tlast, a_mem_we;
  logic [9:0]  a_mem_addr;
  logic [15:0] a_frame_count;

  logic [7:0]  b_s_tdata = 8'd0, b_m_tdata, b_mem_wdata, b_mem_rdata;
  logic        b_s_tvalid = 1'b0, b_s_tready, b_m_tvalid, b_m_tready = 1'b0, b_m_tlast, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [15:0] b_frame_count;

  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];

  always @(posedge clk) begin
    if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
  end
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];

  buffer_stream_ctrl #(.NUM_FRAMES(1024), .LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tlast(a_m_tlast), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .frame_count(a_frame_count)
  );

  buffer_stream_ctrl #(.NUM_FRAMES(1024), .LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .m_axis_tlast(b_m_tlast), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .frame_count(b_frame_count)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int r_first_v, r_last_in, r_last_b;

  // Cycle-driven frame on dut_a: inputs set at negedge, everything observed 1 time unit later.
  task automatic run_frame(input string tag, input logic [31:0] data, input logic [15:0] vpat,
                           input logic [15:0] rpat, input bit hold, input int nmax,
                           input logic [15:0] exp_fc);
    int c = 0, in_idx = 0, nb = 0, we_cnt = 0, extra = 0, stab = 0;
    logic [7:0] od [4];
    logic       ol [4];
    logic [9:0] wa [4];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic       prev_l = 1'b0;
    r_first_v = -1; r_last_in = -1; r_last_b = -1;
    while (nb < nmax && c < 200) begin
      @(negedge clk);
      a_s_tvalid = (in_idx < 4) ? vpat[c % 16] : hold;
      a_s_tdata  = (in_idx < 4) ? data[8*in_idx +: 8] : 8'hEE;
      a_m_tready = rpat[c % 16];
      #1;
      if (prev_stall && (!a_m_tvalid || a_m_tdata != prev_d || a_m_tlast != prev_l)) stab++;
      prev_stall = a_m_tvalid && !a_m_tready;
      prev_d = a_m_tdata;
      prev_l = a_m_tlast;
      if (a_mem_we) begin
        if (we_cnt < 4) wa[we_cnt] = a_mem_addr;
        we_cnt++;
      end
      if (a_s_tvalid && a_s_tready) begin
        if (in_idx < 4) begin
          in_idx++;
          r_last_in = c;
        end else begin
          extra++;
        end
      end
      if (a_m_tvalid && r_first_v < 0) r_first_v = c;
      if (a_m_tvalid && a_m_tready) begin
        if (nb < 4) begin
          od[nb] = a_m_tdata;
          ol[nb] = a_m_tlast;
        end
        nb++;
        r_last_b = c;
      end
      c++;
    end
    check({tag, "_beats"}, nb, nmax);
    for (int i = 0; i < nb && i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), od[i], data[8*i +: 8]);
      check($sformatf("%s_last%0d", tag, i), ol[i], (i == 3) ? 1 : 0);
    end
    check({tag, "_we_count"}, we_cnt, 4);
    for (int i = 0; i < 4 && i < we_cnt; i++)
      check($sformatf("%s_waddr%0d", tag, i), wa[i], i);
    check({tag, "_extra_in"}, extra, 0);
    check({tag, "_stable"}, stab, 0);
    check({tag, "_first_lat"}, r_first_v - r_last_in, 2);
    if (nmax == 4) begin
      @(negedge clk);
      #1;
      check({tag, "_tready_back"}, a_s_tready, 1);
      check({tag, "_frame_count"}, a_frame_count, exp_fc);
      check({tag, "_tvalid_idle"}, a_m_tvalid, 0);
      if (hold) begin
        check({tag, "_next_addr"}, a_mem_addr, 0);
        check({tag, "_next_we"}, a_mem_we, 1);
      end
      a_s_tvalid = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_tready", a_s_tready, 0);
    check("rst_m_tvalid", a_m_tvalid, 0);
    check("rst_m_tlast", a_m_tlast, 0);
    check("rst_m_tdata", a_m_tdata, 0);
    check("rst_frame_count", a_frame_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("tready_after_rst", a_s_tready, 1);

    run_frame("basic", 32'h44332211, 16'hFFFF, 16'hFFFF, 1'b0, 4, 16'd1);
    check("basic_consecutive", r_last_b - r_first_v, 3);

    run_frame("bp", 32'h44332211, 16'hFFFF, 16'b1001_1001_1001_1001, 1'b0, 4, 16'd2);
    run_frame("fstall", 32'hD4C3B2A1, 16'b0110_1010_0101_1001, 16'hFFFF, 1'b0, 4, 16'd3);
    run_frame("push", 32'h78563412, 16'hFFFF, 16'hFFFF, 1'b1, 4, 16'd4);

    @(negedge clk);
    force dut_a.frame_cnt = 16'hFFFF;
    #1;
    release dut_a.frame_cnt;
    #1;
    check("wrap_preload", a_frame_count, 16'hFFFF);
    run_frame("wrap", 32'h0F0E0D0C, 16'hFFFF, 16'hFFFF, 1'b0, 4, 16'h0000);

    run_frame("middrain", 32'h9C9B9A99, 16'hFFFF, 16'hFFFF, 1'b0, 2, 16'd0);
    @(negedge clk);
    rst_n = 1'b0;
    a_m_tready = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_m_tvalid", a_m_tvalid, 0);
    check("mid_rst_frame_count", a_frame_count, 0);
    check("mid_rst_s_tready", a_s_tready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_fill_ready", a_s_tready, 1);
    check("mid_rst_addr", a_mem_addr, 0);
    run_frame("fresh", 32'hA4A3A2A1, 16'hFFFF, 16'hFFFF, 1'b0, 4, 16'd1);

    @(negedge clk);
    b_s_tvalid = 1'b1;
    b_s_tdata  = 8'h5A;
    b_m_tready = 1'b1;
    #1;
    check("len1_s_tready", b_s_tready, 1);
    check("len1_we", b_mem_we, 1);
    check("len1_addr", b_mem_addr, 0);
    @(negedge clk);
    b_s_tvalid = 1'b0;
    #1;
    check("len1_drain_ready", b_s_tready, 0);
    check("len1_drain_tvalid", b_m_tvalid, 0);
    @(negedge clk);
    #1;
    check("len1_tvalid", b_m_tvalid, 1);
    check("len1_tdata", b_m_tdata, 8'h5A);
    check("len1_tlast", b_m_tlast, 1);
    check("len1_flush_addr", b_mem_addr, 0);
    @(negedge clk);
    #1;
    check("len1_done_tvalid", b_m_tvalid, 0);
    check("len1_frame_count", b_frame_count, 1);
    check("len1_ready_back", b_s_tready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
